// File: rtl/updown_arb_pkg.sv
// Shared types and constants for the up/down counter arbiter.
package updown_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RELEASE = 1'b1
    } arb_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_picker
    import updown_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_idx
);

    // Scan offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % NUM_REQ]) begin
                winner_onehot = '0;
                winner_onehot[(int'(ptr) + off) % NUM_REQ] = 1'b1;
                winner_idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/updown_counter_arbiter.sv
// Round-robin arbiter serialising single +/-1 steps onto a shared counter.
// Build option: COUNT_SATURATE_EN clamps at the boundaries instead of wrapping.
module updown_counter_arbiter
    import updown_arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] dir,
    output logic [NUM_REQ-1:0] grant,
    output logic [WIDTH-1:0]   counter,
    output logic               overflow
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [WIDTH-1:0]   counter_d;
    logic               overflow_d;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req           (req),
        .ptr           (ptr_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx)
    );

    // Next-state: grant and step on arbitration, wait for the winner to drop req.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        grant_d    = grant;
        counter_d  = counter;
        overflow_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick_onehot;
                    win_d   = pick_idx;
                    state_d = RELEASE;
                    if (dir[pick_idx] == DIR_UP) begin
                        if (counter == CNT_MAX) begin
                            overflow_d = 1'b1;
`ifdef COUNT_SATURATE_EN
                            counter_d  = CNT_MAX;
`else
                            counter_d  = '0;
`endif
                        end else begin
                            counter_d = counter + 1'b1;
                        end
                    end else begin
                        if (counter == '0) begin
                            overflow_d = 1'b1;
`ifdef COUNT_SATURATE_EN
                            counter_d  = '0;
`else
                            counter_d  = CNT_MAX;
`endif
                        end else begin
                            counter_d = counter - 1'b1;
                        end
                    end
                end
            end
            RELEASE: begin
                if (!req[win_q]) begin
                    grant_d = '0;
                    ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            grant    <= '0;
            counter  <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            grant    <= grant_d;
            counter  <= counter_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters against a
// transaction-level reference model.
module tb_updown_counter_arbiter;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int MAXV = (1 << W) - 1;
`ifdef COUNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] dir = '0;
    logic [N-1:0] grant;
    logic [W-1:0] counter;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: granted requester (-1 = none), count, pointer, overflow
    int m_cnt = 0;
    int m_gnt = -1;
    int m_ptr = 0;
    bit m_ovf = 1'b0;

    logic [N-1:0] order[$];
    int           cnts[$];

    updown_counter_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .dir      (dir),
        .grant    (grant),
        .counter  (counter),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the arbitration rules to the inputs present at this edge.
    task automatic model_edge();
        int nv;
        bit found;
        if (!reset) begin
            m_cnt = 0; m_gnt = -1; m_ptr = 0; m_ovf = 1'b0;
        end else if (m_gnt < 0) begin
            m_ovf = 1'b0;
            if (req != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        m_gnt = (m_ptr + k) % N;
                        found = 1'b1;
                    end
                end
                nv = m_cnt + (dir[m_gnt] ? 1 : -1);
                if (nv > MAXV || nv < 0) begin
                    m_ovf = 1'b1;
                    if (SAT) nv = (nv < 0) ? 0 : MAXV;
                    else     nv = (nv + MAXV + 1) % (MAXV + 1);
                end
                m_cnt = nv;
            end
        end else begin
            m_ovf = 1'b0;
            if (!req[m_gnt]) begin
                m_ptr = (m_gnt + 1) % N;
                m_gnt = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("grant", grant, (m_gnt < 0) ? 0 : (1 << m_gnt));
        check("counter", counter, m_cnt);
        check("overflow", overflow, m_ovf);
    endtask

    // One full handshake by requester i; returns counter/overflow seen with the grant.
    task automatic step_one(input int i, input bit d, output logic [W-1:0] c, output logic o);
        int t;
        req[i] = 1'b1;
        dir[i] = d;
        t = 0;
        while (!grant[i] && t < 20) begin
            tick();
            t++;
        end
        if (!grant[i]) check("grant_timeout", grant, 1 << i);
        c = counter;
        o = overflow;
        req[i] = 1'b0;
        tick();
    endtask

    // Every requester drops on its grant; log grant order and counts.
    task automatic serve_all();
        logic [N-1:0] prev;
        prev = grant;
        order.delete();
        cnts.delete();
        for (int t = 0; t < 64 && (req != '0 || grant != '0); t++) begin
            tick();
            if (grant != '0 && prev == '0) begin
                order.push_back(grant);
                cnts.push_back(int'(counter));
            end
            prev = grant;
            req = req & ~grant;
        end
        if (req != '0 || grant != '0) check("serve_timeout", {req, grant}, 0);
    endtask

    initial begin
        logic [W-1:0] c;
        logic         o;
        logic [N-1:0] rr_exp[4];
        int           guard;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // reset held with all requests pending
        reset = 1'b0; req = '1; dir = '1;
        tick(); tick();
        check("reset_grant", grant, 0);
        check("reset_counter", counter, 0);
        check("reset_overflow", overflow, 0);

        // round robin from ptr=0
        reset = 1'b1;
        serve_all();
        check("rr_len", order.size(), 4);
        for (int k = 0; k < order.size() && k < 4; k++) check("rr_order", order[k], rr_exp[k]);
        check("rr_count", counter, 4);
        step_one(0, 1'b1, c, o);
        check("rr_wrap_count", c, 5);

        // mixed direction, ptr now 1
        dir = 4'b0100;
        req = 4'b0110;
        serve_all();
        check("mix_len", order.size(), 2);
        if (order.size() == 2) begin
            check("mix_g0", order[0], 4'b0010);
            check("mix_c0", cnts[0], 4);
            check("mix_g1", order[1], 4'b0100);
            check("mix_c1", cnts[1], 5);
        end

        // single requester up to the top boundary
        for (int k = 0; k < 10; k++) step_one(3, 1'b1, c, o);
        check("top_count", c, 15);
        check("top_ovf", o, 0);
        step_one(3, 1'b1, c, o);
        check("up_boundary_count", c, SAT ? 15 : 0);
        check("up_boundary_ovf", o, 1);
        check("ovf_one_cycle", overflow, 0);

        // walk down to zero, then step below it
        guard = 0;
        while (m_cnt != 0 && guard < 20) begin
            step_one(1, 1'b0, c, o);
            guard++;
        end
        check("at_zero", counter, 0);
        step_one(1, 1'b0, c, o);
        check("down_boundary_count", c, SAT ? 0 : 15);
        check("down_boundary_ovf", o, 1);

        // reset in the middle of a handshake
        guard = 0;
        while (m_cnt != 6 && guard < 20) begin
            step_one(3, (m_cnt < 6), c, o);
            guard++;
        end
        req[2] = 1'b1; dir[2] = 1'b1;
        guard = 0;
        while (!grant[2] && guard < 20) begin
            tick();
            guard++;
        end
        check("mid_grant", grant, 4'b0100);
        check("mid_count", counter, 7);
        tick();
        reset = 1'b0;
        tick();
        check("mid_reset_grant", grant, 0);
        check("mid_reset_count", counter, 0);
        reset = 1'b1; req = '1; dir = 4'($urandom);
        tick();
        check("post_reset_grant", grant, 4'b0001);

        // randomized requesters
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (grant[i]) begin
                        if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    dir[i] = 1'($urandom_range(0, 1));
                    req[i] = 1'b1;
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/updown_counter_arbiter.md
# updown_counter_arbiter

Round-robin arbiter that shares one up/down counter among NUM_REQ requesters. Each requester asks for a single ±1 step with a four-phase req/grant handshake. The arbiter serialises the steps, applies them to an internal WIDTH-bit counter, and flags boundary hits. It sits in front of the counter datapath as its only write path.

## Interface
- WIDTH, 4, counter width in bits.
- NUM_REQ, 4, number of requesters (≥2).
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising clk edge.
- req  input  NUM_REQ  per-requester step request; held high until its grant bit is seen.
- dir  input  NUM_REQ  per-requester direction, 1 = up, 0 = down; must be stable while the matching req is high.
- grant  output  NUM_REQ  registered one-hot grant, or all zero.
- counter  output  WIDTH  registered shared count.
- overflow  output  1  registered one-cycle pulse on a boundary step.

## Operation
- Reset (reset=0 at an edge) sets the following, regardless of state:
  - counter=0, grant=0, overflow=0
  - round-robin pointer ptr=0
  - state=IDLE
- State IDLE:
  - If req==0: stay in IDLE; grant=0.
  - Else: winner = first set req bit, searching from index ptr upward modulo NUM_REQ.
  - On the same edge:
    - grant[winner] is set.
    - counter steps by ±1 per dir[winner].
    - winner is latched.
    - State goes to RELEASE.
- State RELEASE:
  - grant[winner] stays high while req[winner]=1.
  - req[winner]=0 at an edge causes:
    - grant clears
    - ptr = (winner+1) mod NUM_REQ
    - state goes to IDLE
  - Other req bits are ignored in this state and stay pending.
- Exactly one counter step per grant. dir is sampled only at the grant edge.
- A requester that drops req before being granted is never granted and causes no step.
- Arithmetic is unsigned WIDTH bits. Boundaries are up at 2^WIDTH-1 and down at 0; handling depends on the Configuration macro.
- overflow is 1 for exactly the cycle after a boundary step; otherwise 0.

## Timing
- Request latency: req rising before edge k (state IDLE) gives grant and the new counter visible after edge k (1 cycle).
- Release latency: req falling before edge m gives grant=0 after edge m.
- Earliest re-arbitration is edge m+1.
- Maximum throughput is one step per 2 cycles (grant, release).
- A requester keeping req high never yields. Requesters must drop req within a bounded time after seeing grant.
- Reset mid-RELEASE: grant=0 and counter=0 after that edge. Pending reqs are arbitrated from ptr=0 once reset=1.

## Configuration
- COUNT_SATURATE_EN defined:
  - Up at max holds counter at 2^WIDTH-1.
  - Down at 0 holds counter at 0.
  - overflow pulses; the grant is still issued.
- COUNT_SATURATE_EN undefined:
  - Counter wraps: max+1 becomes 0, and 0-1 becomes 2^WIDTH-1.
  - overflow pulses on the wrap.

## Structure
- Package updown_arb_pkg:
  - state encoding (IDLE, RELEASE)
  - constants DIR_UP=1'b1 and DIR_DOWN=1'b0
- Sub-module rr_picker: combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot winner and winner index.
  - Parameterised by NUM_REQ.
- Counter update and FSM live in updown_counter_arbiter.

## Test plan
Benches use WIDTH=4, NUM_REQ=4.
- Reset: hold reset=0 for 2 edges with req=1111 → counter=0, grant=0000, overflow=0. First grant after release of reset is 0001.
- Single up: three handshakes on req[0] with dir[0]=1, dropping req on each grant → grants 0001 ×3, counter 0→1→2→3, each grant high for 1 cycle after drop latency.
- Round robin: req=1111 with all dir=1, each requester dropping on its grant → grant order 0001, 0010, 0100, 1000, 0001 and counter=5.
- Mixed direction: counter=5, req[1] with dir=0 and req[2] with dir=1 pending, ptr=1 → grant 0010 gives counter=4, then grant 0100 gives counter=5.
- Boundary at counter=15, up step:
  - With COUNT_SATURATE_EN: counter=15 and overflow=1 for one cycle.
  - Without it: counter=0 and overflow=1.
  - Repeat from counter=0 with a down step: saturate gives 0, wrap gives 15, overflow pulses in both builds.
- Reset mid-handshake: with grant=0100 and counter=7, apply reset=0 for one edge → grant=0000 and counter=0. With req=1111 after reset, the first grant is 0001.
